// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite reader control port among N_REQ requesters.
// One read in flight at a time; a watchdog turns a hung reader into an error response.
`timescale 1ns/1ps

module axil_read_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      R_Start,
  output logic [ADDR_W-1:0]         Read_from,
  input  logic [DATA_W-1:0]         R_Data,
  input  logic                      Reader_Run,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_RUN,
    ST_WAIT_DONE,
    ST_RESP,
    ST_DRAIN
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    grant_q;
  logic [WD_W-1:0]     wdog_q;
  logic [WD_W-1:0]     wdog_d;
  logic [ADDR_W-1:0]   read_from_q;
  logic                r_start_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                busy_q;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [N_REQ-1:0]    grant_onehot;
  logic                wdog_expired;

  // Round-robin search starting just after the last winner, wrapping around.
  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  assign win_addr     = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

  // wdog_d is the count this cycle will reach; expiring on TIMEOUT-1 puts the
  // error pulse exactly TIMEOUT cycles after R_Start.
  assign wdog_d       = wdog_q + 1'b1;
  assign wdog_expired = (wdog_d == WD_W'(TIMEOUT - 1));

  // NOTE: state and registered outputs use non-blocking assignments only, so
  // every branch reads the pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      grant_q     <= '0;
      wdog_q      <= '0;
      read_from_q <= '0;
      r_start_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A run already in progress belongs to someone else; wait it out.
          if (win_found && !Reader_Run) begin
            grant_q     <= win_idx;
            rr_ptr_q    <= win_idx;
            read_from_q <= win_addr;
            r_start_q   <= 1'b1;
            wdog_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_START;
          end
        end

        ST_START: begin
          r_start_q <= 1'b0;
          state_q   <= ST_WAIT_RUN;
        end

        ST_WAIT_RUN: begin
          wdog_q <= wdog_d;
          if (wdog_expired) begin
            rsp_valid_q <= grant_onehot;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_DRAIN;
          end else if (Reader_Run) begin
            state_q <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          wdog_q <= wdog_d;
          if (!Reader_Run) begin
            rsp_valid_q <= grant_onehot;
            rsp_data_q  <= R_Data;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else if (wdog_expired) begin
            rsp_valid_q <= grant_onehot;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_DRAIN;
          end
        end

        ST_RESP: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end

        ST_DRAIN: begin
          // The late reader result is discarded; only wait for the run to end.
          rsp_valid_q <= '0;
          if (!Reader_Run) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          r_start_q   <= 1'b0;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign R_Start   = r_start_q;
  assign Read_from = read_from_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

  a_r_start_pulse: assert property (@(posedge ACLK) disable iff (!ARESETn)
    R_Start |=> !R_Start);
  a_rsp_onehot: assert property (@(posedge ACLK) disable iff (!ARESETn)
    $onehot0(rsp_valid));

endmodule
